mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single DDR block port (`ram_en` / `ram_write` / `ram_addr` / `data_to_ram` / `ram_rdy`) of `ddr_ctrl`. It sits between the instruction-cache refill path and the data-cache refill/writeback path inside the memory subsystem. It serialises their block transactions with round-robin arbitration and guarantees the `ram_en` low gap `ddr_ctrl` needs between transactions. It also provides a sticky stuck-transaction watchdog and per-port grant counters for the debug queue.

## Interface
- `ADDR_W`, 30 — word-address width.
- `BLOCK_W`, 256 — cache block width.
- `TO_W`, 12 — watchdog counter width; timeout = 2^TO_W − 1 cycles.
- `CNT_W`, 16 — grant counter width.

- `clk`  in  1  — pipeline clock; all logic on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `ic_req`  in  1  — instruction-side request; held with its fields stable until `ic_done`.
- `ic_addr`  in  `ADDR_W`  — instruction-side block address; always a read.
- `dc_req`  in  1  — data-side request; held with its fields stable until `dc_done`.
- `dc_write`  in  1  — data-side direction: 1 = writeback, 0 = refill.
- `dc_addr`  in  `ADDR_W`  — data-side block address.
- `dc_wdata`  in  `BLOCK_W`  — data-side writeback block.
- `ic_done`, `dc_done`  out  1  — one-cycle completion pulse to the owning port.
- `ram_en`  out  1  — transaction request to `ddr_ctrl`.
- `ram_write`  out  1  — transaction direction to `ddr_ctrl`.
- `ram_addr`  out  `ADDR_W`  — transaction address to `ddr_ctrl`.
- `ram_wdata`  out  `BLOCK_W`  — writeback block to `ddr_ctrl`.
- `ram_rdy`  in  1  — one-cycle completion pulse from `ddr_ctrl`; the read block is broadcast by `ddr_ctrl` directly.
- `owner`  out  1  — current/last owner: 0 = IC, 1 = DC.
- `busy`  out  1  — high while in BUSY.
- `timeout_err`  out  1  — sticky watchdog flag.
- `ic_grants`, `dc_grants`  out  `CNT_W`  — wrapping grant counters.

## Operation
- **States:** IDLE, BUSY, DONE. Reset enters IDLE.
- **IDLE:**
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both request: grant the port that is not `last_grant`. `last_grant` resets to IC, so the first tie goes to DC.
  - On a grant:
    - Register `ram_addr`, `ram_write` (0 for IC, `dc_write` for DC), `ram_wdata` (DC only; unchanged for IC) and `owner`.
    - Set `ram_en` = 1 and `last_grant` = owner.
    - Increment the owner's grant counter, wrapping modulo 2^`CNT_W`.
    - Go to BUSY.
- **BUSY:**
  - `ram_en` stays 1 and all `ram_*` outputs are frozen.
  - Requester `req` changes are ignored.
  - On `ram_rdy`: go to DONE.
- **DONE:**
  - `ram_en` = 0.
  - Pulse the owner's `done` for exactly this cycle.
  - Go unconditionally to IDLE.
- **Back-to-back:** a requester may keep `req` high after its done pulse; IDLE samples it as a new request.
- **`ram_rdy` outside BUSY:** ignored; no state or output change.
- **Watchdog:**
  - The counter clears on entry to BUSY and increments each BUSY cycle.
  - At all-ones it saturates and sets `timeout_err`.
  - The transaction is not aborted; the FSM stays in BUSY until `ram_rdy`.
  - `timeout_err` clears only on reset.
- **Reset:**
  - Asynchronous assertion at any time forces IDLE, `ram_en` = 0, both dones = 0, `last_grant` = IC, counters = 0 and `timeout_err` = 0.
  - An in-flight transaction is dropped; `ddr_ctrl` shares `rst`.
- **Reset values of outputs:** `ram_en` 0, `ram_write` 0, `ram_addr` 0, `ram_wdata` 0, `ic_done`/`dc_done` 0, `owner` 0, `busy` 0, `timeout_err` 0, `ic_grants`/`dc_grants` 0.

## Timing
- All outputs are registered; there is no combinational path from the `req` or `ram_rdy` inputs to any output.
- A request sampled in IDLE at edge N gives `ram_en` = 1 from N+1.
- `ram_rdy` sampled at edge M gives:
  - `done` high and `ram_en` low for cycle M+1;
  - IDLE during M+2;
  - the earliest next `ram_en` at M+3.
- Minimum `ram_en` low gap between transactions: 2 cycles.
- A single request with `ram_rdy` after k BUSY cycles completes in k+2 cycles from grant to done.

## Structure
- Shared package `mem_if_pkg`:
  - FSM state encoding (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2);
  - owner encoding (OWNER_IC = 0, OWNER_DC = 1);
  - the `ADDR_W` and `BLOCK_W` defaults, shared with `cache_manage_unit`.
- One natural sub-module, `stall_watchdog`: a saturating counter with clear/enable inputs and a sticky flag output, reusable for the VGA and trap stall paths.
- Everything else stays flat in `mem_port_arbiter`.

## Test plan
- **Single IC read:** `ic_req` = 1, `ic_addr` = 30'h100, `ram_rdy` 5 cycles after `ram_en` rises → `ram_en` 1 for 5 cycles, `ram_write` 0, `ram_addr` 30'h100, `ic_done` single pulse one cycle after `ram_rdy`, `ic_grants` = 1.
- **Tie after reset:** `ic_req` and `dc_req` (write, `dc_addr` 30'h2000, `dc_wdata` = {8{32'hDEADBEEF}}) asserted in the same cycle → DC served first with `ram_write` 1 and matching data, then IC; exactly 2 idle `ram_en` cycles between the two transactions.
- **Fairness:** both requests held continuously for 6 transactions → grants alternate DC, IC, DC, IC, DC, IC; both counters = 3.
- **Stray `ram_rdy`:** `ram_rdy` pulsed in IDLE and in DONE → no state change, no done pulse, counters unchanged.
- **Watchdog:** `TO_W` = 4, `ram_rdy` withheld for 20 cycles → `timeout_err` rises after 15 BUSY cycles and stays high; a later `ram_rdy` still completes with `dc_done`; `timeout_err` clears only on `rst`.
- **Reset in BUSY:** `rst` low mid-BUSY → `ram_en`, `busy` and dones go to 0 immediately (asynchronously); after release with `ic_req` and `dc_req` both high, DC is granted first.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions: FSM state codes, owner codes and the
// default address/block widths used by the memory subsystem.
package mem_if_pkg;

    localparam int ADDR_W_DEF  = 30;
    localparam int BLOCK_W_DEF = 256;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    // Round-robin pick between the two ports: a lone request wins outright,
    // a tie goes to whichever port was not granted last.
    function automatic logic pickDc(input logic icReq, input logic dcReq,
                                    input logic lastGrant);
        return dcReq && (!icReq || (lastGrant == OWNER_IC));
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Saturating stall counter with a sticky flag. The counter is cleared by
// clear_i and counts while enable_i is high; reaching all-ones sets the flag,
// which only reset can clear.
module stall_watchdog #(
    parameter int W = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic flag_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q, count_d;
    logic         flag_q, flag_d;

    // Next count: clear wins, otherwise count up while enabled and not saturated.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + W'(1);
        end
        flag_d = flag_q | (count_d == CNT_MAX);
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the ddr_ctrl block port.
// Serialises IC refills and DC refills/writebacks, keeps ram_en low for two
// cycles between transactions, and tracks grants plus a stuck-transaction flag.
module mem_port_arbiter
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int TO_W    = 12,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ic_req,
    input  logic [ADDR_W-1:0]  ic_addr,
    input  logic               dc_req,
    input  logic               dc_write,
    input  logic [ADDR_W-1:0]  dc_addr,
    input  logic [BLOCK_W-1:0] dc_wdata,
    output logic               ic_done,
    output logic               dc_done,
    output logic               ram_en,
    output logic               ram_write,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [BLOCK_W-1:0] ram_wdata,
    input  logic               ram_rdy,
    output logic               owner,
    output logic               busy,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   ic_grants,
    output logic [CNT_W-1:0]   dc_grants
);

    logic [1:0]         state_q, state_d;
    logic               ramEn_q, ramEn_d;
    logic               ramWrite_q, ramWrite_d;
    logic [ADDR_W-1:0]  ramAddr_q, ramAddr_d;
    logic [BLOCK_W-1:0] ramWdata_q, ramWdata_d;
    logic               icDone_q, icDone_d;
    logic               dcDone_q, dcDone_d;
    logic               owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]   icGrants_q, icGrants_d;
    logic [CNT_W-1:0]   dcGrants_q, dcGrants_d;
    logic               grantDc;
    logic               wdClear;
    logic               wdFlag;

    // Next-state logic: arbitrate in IDLE, hold the port frozen in BUSY until
    // ram_rdy, then spend one DONE cycle with ram_en low and the done pulse.
    always_comb begin
        state_d     = state_q;
        ramEn_d     = ramEn_q;
        ramWrite_d  = ramWrite_q;
        ramAddr_d   = ramAddr_q;
        ramWdata_d  = ramWdata_q;
        icDone_d    = 1'b0;
        dcDone_d    = 1'b0;
        owner_d     = owner_q;
        busy_d      = busy_q;
        lastGrant_d = lastGrant_q;
        icGrants_d  = icGrants_q;
        dcGrants_d  = dcGrants_q;
        grantDc     = 1'b0;
        wdClear     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    grantDc     = pickDc(ic_req, dc_req, lastGrant_q);
                    wdClear     = 1'b1;
                    ramEn_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = BUSY;
                    owner_d     = grantDc ? OWNER_DC : OWNER_IC;
                    lastGrant_d = owner_d;
                    if (grantDc) begin
                        ramWrite_d = dc_write;
                        ramAddr_d  = dc_addr;
                        ramWdata_d = dc_wdata;
                        dcGrants_d = dcGrants_q + CNT_W'(1);
                    end else begin
                        ramWrite_d = 1'b0;
                        ramAddr_d  = ic_addr;
                        icGrants_d = icGrants_q + CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (ram_rdy) begin
                    state_d = DONE;
                    ramEn_d = 1'b0;
                    busy_d  = 1'b0;
                    if (owner_q == OWNER_DC) begin
                        dcDone_d = 1'b1;
                    end else begin
                        icDone_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ramEn_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ramEn_q     <= 1'b0;
            ramWrite_q  <= 1'b0;
            ramAddr_q   <= '0;
            ramWdata_q  <= '0;
            icDone_q    <= 1'b0;
            dcDone_q    <= 1'b0;
            owner_q     <= OWNER_IC;
            busy_q      <= 1'b0;
            lastGrant_q <= OWNER_IC;
            icGrants_q  <= '0;
            dcGrants_q  <= '0;
        end else begin
            state_q     <= state_d;
            ramEn_q     <= ramEn_d;
            ramWrite_q  <= ramWrite_d;
            ramAddr_q   <= ramAddr_d;
            ramWdata_q  <= ramWdata_d;
            icDone_q    <= icDone_d;
            dcDone_q    <= dcDone_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            lastGrant_q <= lastGrant_d;
            icGrants_q  <= icGrants_d;
            dcGrants_q  <= dcGrants_d;
        end
    end

    stall_watchdog #(
        .W (TO_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (wdClear),
        .enable_i (state_q == BUSY),
        .flag_o   (wdFlag)
    );

    assign ram_en      = ramEn_q;
    assign ram_write   = ramWrite_q;
    assign ram_addr    = ramAddr_q;
    assign ram_wdata   = ramWdata_q;
    assign ic_done     = icDone_q;
    assign dc_done     = dcDone_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign timeout_err = wdFlag;
    assign ic_grants   = icGrants_q;
    assign dc_grants   = dcGrants_q;

endmodule
